uart_alu_ctrl: RTL and testbench

UART_ALU_CTRL -- requirements
Module: uart_alu_ctrl

---
 rtl/uart_alu_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_uart_alu_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_alu_ctrl.sv
// uart_alu_ctrl
//   Frames a three-byte command received from a UART RX (operand A, operand B,
//   opcode), presents the operands and opcode to an external combinational ALU,
//   gives the ALU one cycle to settle, then captures its result and requests a
//   single UART TX transmission. Waits for the transmitter to finish before
//   accepting the next frame. Bytes that arrive while busy are dropped and
//   flagged as overrun.
//
// Optional feature (macro UART_ALU_CTRL_TIMEOUT_EN):
//   When defined, an inter-byte timeout abandons a partial frame if the next
//   byte does not arrive within TIMEOUT_CYCLES cycles of entering WAIT_B or
//   WAIT_OP. When undefined, no counter exists, timeout is tied low and the
//   FSM waits indefinitely for the next byte.
//
// Parameters
//   N              operand / result / UART byte width
//   OP_W           ALU opcode width (OP_W <= N), taken from the low opcode bits
//   TIMEOUT_CYCLES inter-byte timeout in clk cycles
//
// Ports
//   clk        in   single clock, rising edge
//   reset      in   synchronous active-low reset
//   rx_data    in   [N]    received byte
//   rx_valid   in   1-cycle pulse qualifying rx_data
//   alu_result in   [N]    combinational ALU result
//   tx_done    in   1-cycle pulse at end of TX stop bit
//   alu_a      out  [N]    registered operand A
//   alu_b      out  [N]    registered operand B
//   alu_op     out  [OP_W] registered opcode
//   tx_data    out  [N]    registered byte to transmit
//   tx_start   out  1-cycle transmit request (high while in SEND)
//   overrun    out  sticky: a byte was dropped while busy
//   timeout    out  1-cycle pulse on inter-byte timeout
//   state      out  [3]    current FSM state code (debug)
module uart_alu_ctrl #(
  parameter int N              = 8,
  parameter int OP_W           = 6,
  parameter int TIMEOUT_CYCLES = 5208*12
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    rx_data,
  input  logic            rx_valid,
  input  logic [N-1:0]    alu_result,
  input  logic            tx_done,
  output logic [N-1:0]    alu_a,
  output logic [N-1:0]    alu_b,
  output logic [OP_W-1:0] alu_op,
  output logic [N-1:0]    tx_data,
  output logic            tx_start,
  output logic            overrun,
  output logic            timeout,
  output logic [2:0]      state
);

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    EXEC    = 3'd3,
    SEND    = 3'd4,
    WAIT_TX = 3'd5
  } state_t;

  state_t          state_q,    state_d;
  logic [N-1:0]    alu_a_q,    alu_a_d;
  logic [N-1:0]    alu_b_q,    alu_b_d;
  logic [OP_W-1:0] alu_op_q,   alu_op_d;
  logic [N-1:0]    tx_data_q,  tx_data_d;
  logic            tx_start_q, tx_start_d;
  logic            overrun_q,  overrun_d;

`ifdef UART_ALU_CTRL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic             timeout_q, timeout_d;
`endif

  always_comb begin
    state_d   = state_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_op_d  = alu_op_q;
    tx_data_d = tx_data_q;
    overrun_d = overrun_q;
`ifdef UART_ALU_CTRL_TIMEOUT_EN
    // Counter is zero whenever we are not waiting for B or OP, so every entry
    // into those states starts counting from zero.
    cnt_d     = '0;
    timeout_d = 1'b0;
`endif

    case (state_q)
      WAIT_A: begin
        if (rx_valid) begin
          alu_a_d = rx_data;
          state_d = WAIT_B;
        end
      end
      WAIT_B: begin
        // An arriving byte wins over an expiring counter.
        if (rx_valid) begin
          alu_b_d = rx_data;
          state_d = WAIT_OP;
        end
`ifdef UART_ALU_CTRL_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          state_d   = WAIT_A;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      WAIT_OP: begin
        if (rx_valid) begin
          alu_op_d = rx_data[OP_W-1:0];
          state_d  = EXEC;
        end
`ifdef UART_ALU_CTRL_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          state_d   = WAIT_A;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      EXEC: begin
        // alu_op became valid at the start of this cycle; the ALU settles here.
        if (rx_valid) overrun_d = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        if (rx_valid) overrun_d = 1'b1;
        tx_data_d = alu_result;
        state_d   = WAIT_TX;
      end
      WAIT_TX: begin
        // A byte coincident with tx_done is still dropped.
        if (rx_valid) overrun_d = 1'b1;
        if (tx_done)  state_d   = WAIT_A;
      end
      default: begin
        state_d = WAIT_A;
      end
    endcase

    // Registered so tx_start is high exactly during the SEND cycle.
    tx_start_d = (state_d == SEND);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= WAIT_A;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      overrun_q  <= 1'b0;
`ifdef UART_ALU_CTRL_TIMEOUT_EN
      cnt_q      <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      overrun_q  <= overrun_d;
`ifdef UART_ALU_CTRL_TIMEOUT_EN
      cnt_q      <= cnt_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_op   = alu_op_q;
  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign overrun  = overrun_q;
  assign state    = state_q;

`ifdef UART_ALU_CTRL_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Testbench for uart_alu_ctrl: drives byte frames, stubs the ALU, and checks
// transmitted results through a scoreboard queue.
module tb_uart_alu_ctrl;

  localparam int N    = 8;
  localparam int OP_W = 6;
  localparam int TOC  = 100;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    rx_data;
  logic            rx_valid;
  logic [N-1:0]    alu_result;
  logic            tx_done;
  logic [N-1:0]    alu_a;
  logic [N-1:0]    alu_b;
  logic [OP_W-1:0] alu_op;
  logic [N-1:0]    tx_data;
  logic            tx_start;
  logic            overrun;
  logic            timeout;
  logic [2:0]      state;

  int checks = 0;
  int errors = 0;
  int n_start = 0;
  logic [N-1:0] sb[$];

  always #5 clk = ~clk;

  uart_alu_ctrl #(.N(N), .OP_W(OP_W), .TIMEOUT_CYCLES(TOC)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .alu_result(alu_result), .tx_done(tx_done), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .tx_data(tx_data), .tx_start(tx_start),
    .overrun(overrun), .timeout(timeout), .state(state)
  );

  // ALU stub: opcode 0x20 adds, anything else XORs.
  assign alu_result = (alu_op == 6'h20) ? alu_a + alu_b : alu_a ^ alu_b;

  function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] op);
    return (op == 6'h20) ? a + b : a ^ b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // tx_data is captured at the end of the SEND cycle, so compare it one
  // cycle after tx_start is seen.
  logic start_seen = 1'b0;
  always @(negedge clk) begin
    if (start_seen) begin
      if (sb.size() == 0) chk("sb_unexpected_tx", 32'(tx_data), 32'hFFFF_FFFF);
      else                chk("sb_tx_data", 32'(tx_data), 32'(sb.pop_front()));
    end
    start_seen = tx_start;
    if (tx_start) n_start++;
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic tx_done_pulse();
    @(posedge clk); #1;
    tx_done = 1'b1;
    @(posedge clk); #1;
    tx_done = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] opb, input bit done);
    sb.push_back(alu_model(a, b, opb[5:0]));
    send_byte(a);
    chk("st_wait_b", 32'(state), 32'd1);
    send_byte(b);
    chk("st_wait_op", 32'(state), 32'd2);
    send_byte(opb);
    @(negedge clk);
    chk("st_exec", 32'(state), 32'd3);
    chk("start_in_exec", 32'(tx_start), 32'd0);
    @(negedge clk);
    chk("st_send", 32'(state), 32'd4);
    chk("start_in_send", 32'(tx_start), 32'd1);
    chk("alu_a", 32'(alu_a), 32'(a));
    chk("alu_b", 32'(alu_b), 32'(b));
    chk("alu_op", 32'(alu_op), 32'(opb[5:0]));
    if (done) begin
      tx_done_pulse();
      chk("st_after_done", 32'(state), 32'd0);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_state"},   32'(state),    32'd0);
    chk({tag, "_alu_a"},   32'(alu_a),    32'd0);
    chk({tag, "_alu_b"},   32'(alu_b),    32'd0);
    chk({tag, "_alu_op"},  32'(alu_op),   32'd0);
    chk({tag, "_tx_data"}, 32'(tx_data),  32'd0);
    chk({tag, "_start"},   32'(tx_start), 32'd0);
    chk({tag, "_overrun"}, 32'(overrun),  32'd0);
    chk({tag, "_timeout"}, 32'(timeout),  32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int at;
    int starts_before;
    reset    = 1'b0;
    rx_data  = '0;
    rx_valid = 1'b0;
    tx_done  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset = 1'b1;

    // tx_done outside WAIT_TX is ignored
    tx_done_pulse();
    chk("ign_done_state", 32'(state), 32'd0);
    chk("ign_done_start", 32'(tx_start), 32'd0);

    // Basic frame: 5 + 3 = 8
    send_frame(8'h05, 8'h03, 8'h20, 1'b1);

    // Opcode uses low 6 bits only: 0xE2 -> 0x22 (XOR in stub)
    send_frame(8'h10, 8'h32, 8'hE2, 1'b1);

    // Back-to-back frames, overrun must stay clear
    send_frame(8'h55, 8'hAA, 8'h20, 1'b1);
    send_frame(8'hAA, 8'h55, 8'h20, 1'b1);
    chk("b2b_overrun", 32'(overrun), 32'd0);
    chk("b2b_starts", 32'(n_start), 32'd4);

    // Byte in WAIT_TX dropped, overrun set; a byte coincident with tx_done too
    send_frame(8'h05, 8'h03, 8'h20, 1'b0);
    send_byte(8'hAA);
    chk("ovr_flag", 32'(overrun), 32'd1);
    chk("ovr_alu_a", 32'(alu_a), 32'h05);
    chk("ovr_state", 32'(state), 32'd5);
    @(posedge clk); #1;
    rx_data  = 8'hBB;
    rx_valid = 1'b1;
    tx_done  = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    tx_done  = 1'b0;
    chk("ovr_done_state", 32'(state), 32'd0);
    chk("ovr_done_alu_a", 32'(alu_a), 32'h05);
    @(posedge clk); #1;
    chk("ovr_sticky_state", 32'(state), 32'd0);
    chk("ovr_sticky", 32'(overrun), 32'd1);

    // Reset mid-frame in WAIT_OP
    send_byte(8'h55);
    send_byte(8'h66);
    chk("mid_state", 32'(state), 32'd2);
    chk("mid_alu_a", 32'(alu_a), 32'h55);
    do_reset();
    chk_all_zero("midrst");
    send_frame(8'h07, 8'h02, 8'h20, 1'b1);

`ifdef UART_ALU_CTRL_TIMEOUT_EN
    // Idle after one byte: exactly one pulse, TOC cycles after WAIT_B entry
    send_byte(8'h11);
    pulses = 0;
    at = -1;
    for (int k = 0; k < TOC + 10; k++) begin
      @(negedge clk);
      if (timeout) begin
        pulses++;
        at = k;
      end
    end
    chk("to_pulses", 32'(pulses), 32'd1);
    chk("to_cycle", 32'(at), 32'(TOC));
    chk("to_state", 32'(state), 32'd0);

    // Byte exactly in the expiry cycle is accepted, no pulse
    send_byte(8'h11);
    pulses = 0;
    repeat (TOC - 2) begin
      @(posedge clk);
      if (timeout) pulses++;
    end
    send_byte(8'h22);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (timeout) pulses++;
    end
    chk("to_exp_pulses", 32'(pulses), 32'd0);
    chk("to_exp_state", 32'(state), 32'd2);
    chk("to_exp_alu_b", 32'(alu_b), 32'h22);
    do_reset();
`else
    // No timeout feature: wait in WAIT_B indefinitely
    send_byte(8'h11);
    pulses = 0;
    for (int k = 0; k < TOC + 50; k++) begin
      @(negedge clk);
      if (timeout) pulses++;
    end
    chk("noto_pulses", 32'(pulses), 32'd0);
    chk("noto_state", 32'(state), 32'd1);
    do_reset();
`endif

    starts_before = n_start;
    repeat (4) @(posedge clk);
    chk("final_no_stray_start", 32'(n_start), 32'(starts_before));
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
